// File: rtl/id_exe_reg_pkg.sv
// Shared CPU package: EXE_CMD and branch-type encodings used by decode, the
// ID/EXE pipeline register and EXE, plus the packed control bundle layout.
package id_exe_reg_pkg;

    localparam int CMD_W     = 4;
    localparam int BR_W      = 2;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEZ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JMP  = 2'b11
    } br_type_e;

    typedef enum logic [3:0] {
        EXE_ADD = 4'b0000,
        EXE_SUB = 4'b0010,
        EXE_AND = 4'b0100,
        EXE_OR  = 4'b0101,
        EXE_NOR = 4'b0110,
        EXE_XOR = 4'b0111,
        EXE_SHL = 4'b1000,
        EXE_SRA = 4'b1001,
        EXE_SRL = 4'b1010
    } exe_cmd_e;

    // Control bundle carried from ID to EXE; valid rides along so that a
    // squash clears it together with the side-effecting control bits.
    typedef struct packed {
        logic [CMD_W-1:0]     exe_cmd;
        logic                 is_immediate;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 wb_en;
        logic [BR_W-1:0]      br_type;
        logic [REG_IDX_W-1:0] dest;
        logic                 valid;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_exe_reg_pipe_reg.sv
// Generic pipeline storage register: synchronous reset, clear over enable.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Next-state select: clear wins over load, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (en) begin
            data_d = d;
        end else begin
            data_d = data_q;
        end
    end

    // Storage flops with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze, flush/bubble squash and saturating
// squash-event counters.
module id_exe_reg #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              bubble,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [3:0]        EXE_CMD_in,
    input  logic              is_immediate_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic              WB_EN_in,
    input  logic [1:0]        br_type_in,
    input  logic [WORD_W-1:0] val1_in,
    input  logic [WORD_W-1:0] val2_in,
    input  logic [WORD_W-1:0] st_val_in,
    input  logic [4:0]        dest_in,
    input  logic [4:0]        src1_in,
    input  logic [4:0]        src2_in,
    output logic [WORD_W-1:0] pc_out,
    output logic [3:0]        EXE_CMD,
    output logic              is_immediate,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic              WB_EN,
    output logic [1:0]        br_type,
    output logic [WORD_W-1:0] val1,
    output logic [WORD_W-1:0] val2,
    output logic [WORD_W-1:0] st_val,
    output logic [4:0]        dest,
    output logic [4:0]        src1,
    output logic [4:0]        src2,
    output logic              valid,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import id_exe_reg_pkg::*;

    localparam int DATA_W = 4 * WORD_W + 2 * REG_IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t              ctrl_in_s;
    ctrl_t              ctrl_out_s;
    logic [CTRL_W-1:0]  ctrl_q_s;
    logic [DATA_W-1:0]  data_in_s;
    logic [DATA_W-1:0]  data_q_s;
    logic               load_en_s;
    logic               squash_s;
    logic [CNT_W-1:0]   flush_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q;
    logic [CNT_W-1:0]   bubble_cnt_d;
    logic [CNT_W-1:0]   bubble_cnt_q;

    // Stage control: freeze blocks everything, squash only applies when not frozen.
    always_comb begin
        load_en_s = ~freeze;
        squash_s  = ~freeze & (flush | bubble);
    end

    // Pack decode outputs into the control bundle; a loaded slot is valid.
    always_comb begin
        ctrl_in_s              = '0;
        ctrl_in_s.exe_cmd      = EXE_CMD_in;
        ctrl_in_s.is_immediate = is_immediate_in;
        ctrl_in_s.mem_r_en     = MEM_R_EN_in;
        ctrl_in_s.mem_w_en     = MEM_W_EN_in;
        ctrl_in_s.wb_en        = WB_EN_in;
        ctrl_in_s.br_type      = br_type_in;
        ctrl_in_s.dest         = dest_in;
        ctrl_in_s.valid        = 1'b1;
    end

    assign data_in_s = {pc_in, val1_in, val2_in, st_val_in, src1_in, src2_in};

    pipe_reg #(.W(CTRL_W)) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .en  (load_en_s),
        .clr (squash_s),
        .d   (ctrl_in_s),
        .q   (ctrl_q_s)
    );

    pipe_reg #(.W(DATA_W)) u_data_reg (
        .clk (clk),
        .rst (rst),
        .en  (load_en_s),
        .clr (squash_s),
        .d   (data_in_s),
        .q   (data_q_s)
    );

    // Squash counters: flush takes precedence over bubble, both saturate.
    always_comb begin
        flush_cnt_d  = flush_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (freeze) begin
            flush_cnt_d  = flush_cnt_q;
            bubble_cnt_d = bubble_cnt_q;
        end else if (flush) begin
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end else if (bubble) begin
            if (bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
            end else begin
                bubble_cnt_d = bubble_cnt_q;
            end
        end else begin
            flush_cnt_d  = flush_cnt_q;
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Counter flops with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            flush_cnt_q  <= flush_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ctrl_out_s   = ctrl_t'(ctrl_q_s);
    assign EXE_CMD      = ctrl_out_s.exe_cmd;
    assign is_immediate = ctrl_out_s.is_immediate;
    assign MEM_R_EN     = ctrl_out_s.mem_r_en;
    assign MEM_W_EN     = ctrl_out_s.mem_w_en;
    assign WB_EN        = ctrl_out_s.wb_en;
    assign br_type      = ctrl_out_s.br_type;
    assign dest         = ctrl_out_s.dest;
    assign valid        = ctrl_out_s.valid;

    assign {pc_out, val1, val2, st_val, src1, src2} = data_q_s;

    assign flush_cnt  = flush_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: directed steps, a reference model
// pushing expected stage contents into a scoreboard queue each cycle.
module tb_id_exe_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, bubble;
    logic [31:0] pc_in, val1_in, val2_in, st_val_in;
    logic [3:0]  EXE_CMD_in;
    logic        is_immediate_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
    logic [1:0]  br_type_in;
    logic [4:0]  dest_in, src1_in, src2_in;

    logic [31:0] pc_out, val1, val2, st_val;
    logic [3:0]  EXE_CMD;
    logic        is_immediate, MEM_R_EN, MEM_W_EN, WB_EN, valid;
    logic [1:0]  br_type;
    logic [4:0]  dest, src1, src2;
    logic [3:0]  bubble_cnt, flush_cnt;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cmd;
        logic        imm, mr, mw, wb;
        logic [1:0]  br;
        logic [31:0] v1, v2, st;
        logic [4:0]  dst, s1, s2;
        logic        vld;
        logic [3:0]  bcnt, fcnt;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    id_exe_reg #(.WORD_W(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
        .pc_in(pc_in), .EXE_CMD_in(EXE_CMD_in), .is_immediate_in(is_immediate_in),
        .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
        .br_type_in(br_type_in), .val1_in(val1_in), .val2_in(val2_in),
        .st_val_in(st_val_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
        .pc_out(pc_out), .EXE_CMD(EXE_CMD), .is_immediate(is_immediate),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .br_type(br_type),
        .val1(val1), .val2(val2), .st_val(st_val), .dest(dest), .src1(src1),
        .src2(src2), .valid(valid), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    // Reference behaviour: rst > freeze > flush > bubble > load.
    function automatic exp_t model_next(input exp_t cur);
        exp_t n;
        n = cur;
        if (rst) begin
            n = '0;
        end else if (freeze) begin
            n = cur;
        end else if (flush || bubble) begin
            n = '0;
            n.fcnt = cur.fcnt;
            n.bcnt = cur.bcnt;
            if (flush) begin
                if (cur.fcnt != 4'd15) n.fcnt = cur.fcnt + 4'd1;
            end else begin
                if (cur.bcnt != 4'd15) n.bcnt = cur.bcnt + 4'd1;
            end
        end else begin
            n.pc = pc_in;  n.cmd = EXE_CMD_in; n.imm = is_immediate_in;
            n.mr = MEM_R_EN_in; n.mw = MEM_W_EN_in; n.wb = WB_EN_in;
            n.br = br_type_in; n.v1 = val1_in; n.v2 = val2_in; n.st = st_val_in;
            n.dst = dest_in; n.s1 = src1_in; n.s2 = src2_in; n.vld = 1'b1;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("pc_out",       pc_out,       e.pc);
            chk("EXE_CMD",      {28'd0, EXE_CMD},      {28'd0, e.cmd});
            chk("is_immediate", {31'd0, is_immediate}, {31'd0, e.imm});
            chk("MEM_R_EN",     {31'd0, MEM_R_EN},     {31'd0, e.mr});
            chk("MEM_W_EN",     {31'd0, MEM_W_EN},     {31'd0, e.mw});
            chk("WB_EN",        {31'd0, WB_EN},        {31'd0, e.wb});
            chk("br_type",      {30'd0, br_type},      {30'd0, e.br});
            chk("val1",         val1,         e.v1);
            chk("val2",         val2,         e.v2);
            chk("st_val",       st_val,       e.st);
            chk("dest",         {27'd0, dest},         {27'd0, e.dst});
            chk("src1",         {27'd0, src1},         {27'd0, e.s1});
            chk("src2",         {27'd0, src2},         {27'd0, e.s2});
            chk("valid",        {31'd0, valid},        {31'd0, e.vld});
            chk("bubble_cnt",   {28'd0, bubble_cnt},   {28'd0, e.bcnt});
            chk("flush_cnt",    {28'd0, flush_cnt},    {28'd0, e.fcnt});
        end
    endtask

    // One clock: predict, push, clock, sample 1 time unit after the edge, compare.
    task automatic step();
        m = model_next(m);
        sb.push_back(m);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic set_in(input logic [31:0] pc, input logic [3:0] cmd, input logic imm,
                          input logic mr, input logic mw, input logic wb, input logic [1:0] br,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] st,
                          input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        pc_in = pc; EXE_CMD_in = cmd; is_immediate_in = imm; MEM_R_EN_in = mr;
        MEM_W_EN_in = mw; WB_EN_in = wb; br_type_in = br; val1_in = v1; val2_in = v2;
        st_val_in = st; dest_in = d; src1_in = s1; src2_in = s2;
    endtask

    initial begin
        m = '0;
        // Reset with every input nonzero, all stage controls active.
        rst = 1'b1; freeze = 1'b1; flush = 1'b1; bubble = 1'b1;
        set_in(32'hFFFF_FFFC, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11,
               32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd31, 5'd30, 5'd29);
        #2;
        step();

        // ADD load.
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; bubble = 1'b0;
        set_in(32'd4, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,
               32'd5, 32'd7, 32'd0, 5'd3, 5'd1, 5'd2);
        step();

        // Store, then freeze three cycles with changing inputs.
        set_in(32'd8, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00,
               32'd100, 32'd4, 32'hDEAD_BEEF, 5'd0, 5'd6, 5'd7);
        step();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(32'd12 + 32'(i), 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10,
                   32'(i), 32'(i + 9), 32'h0BAD_0000 + 32'(i), 5'd9, 5'd10, 5'd11);
            flush  = i[0];
            bubble = ~i[0];
            step();
        end

        // Flush and bubble together: treated as flush.
        freeze = 1'b0; flush = 1'b1; bubble = 1'b1;
        set_in(32'd20, 4'b0101, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11,
               32'd1, 32'd2, 32'd3, 5'd4, 5'd5, 5'd6);
        step();

        // Reload, then freeze+flush holds, then flush alone squashes.
        flush = 1'b0; bubble = 1'b0;
        step();
        freeze = 1'b1; flush = 1'b1;
        step();
        freeze = 1'b0;
        step();

        // Randomised traffic with occasional stalls and squashes.
        for (int i = 0; i < 30; i++) begin
            set_in($urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                   5'($urandom), 5'($urandom), 5'($urandom));
            freeze = ($urandom_range(0, 5) == 0);
            flush  = ($urandom_range(0, 4) == 0);
            bubble = ($urandom_range(0, 3) == 0);
            step();
        end

        // Reset during freeze, then normal load on the first free edge.
        freeze = 1'b1; rst = 1'b1; flush = 1'b0; bubble = 1'b0;
        step();
        rst = 1'b0; freeze = 1'b0;
        set_in(32'h40, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01,
               32'h80, 32'h3, 32'h0, 5'd12, 5'd13, 5'd14);
        step();

        // Twenty bubbles: counter saturates at 15.
        bubble = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        chk("bubble_cnt_sat", {28'd0, bubble_cnt}, 32'd15);
        bubble = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
